bf16_round_pipe: RTL and testbench



---
 rtl/bf16_round_pipe.sv | 164 ++++++++++++++++
 tb/tb_bf16_round_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_round_pipe.sv
// Two-stage FP narrowing rounder (FP32 -> BF16 by default) with valid/ready backpressure.
// Define BF16_ROUND_FLAGS_EN to build the {overflow, inexact} flag path; otherwise out_flags is 0.
module bf16_round_pipe #(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned IN_MAN_W  = 23,
    parameter int unsigned OUT_MAN_W = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_W+IN_MAN_W:0]        in_data,
    input  logic [1:0]                     in_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_W+OUT_MAN_W:0]       out_data,
    output logic [1:0]                     out_flags
);

    localparam int unsigned D     = IN_MAN_W - OUT_MAN_W;
    localparam int unsigned SUM_W = EXP_W + OUT_MAN_W;
    localparam logic [OUT_MAN_W-1:0] QNAN_FRAC = OUT_MAN_W'(1) << (OUT_MAN_W - 1);

    if (IN_MAN_W < OUT_MAN_W + 2) begin : g_bad_params
        $error("bf16_round_pipe: IN_MAN_W must be at least OUT_MAN_W + 2");
    end

    typedef enum logic [1:0] {ClsFinite, ClsInf, ClsNan} cls_e;

    // ---------------- stage 1: decode and rounding decision ----------------
    logic                  sign_in;
    logic [EXP_W-1:0]      exp_in;
    logic [IN_MAN_W-1:0]   frac_in;
    logic [OUT_MAN_W-1:0]  kept_in;
    logic                  lsb_in, g_in, s_in, inc_in;
    cls_e                  cls_in;

    assign sign_in = in_data[EXP_W+IN_MAN_W];
    assign exp_in  = in_data[EXP_W+IN_MAN_W-1:IN_MAN_W];
    assign frac_in = in_data[IN_MAN_W-1:0];
    assign kept_in = frac_in[IN_MAN_W-1:D];
    assign lsb_in  = frac_in[D];
    assign g_in    = frac_in[D-1];
    assign s_in    = |frac_in[D-2:0];

    always_comb begin
        inc_in = 1'b0;
        unique case (in_mode)
            2'b00:   inc_in = g_in & (s_in | lsb_in);
            2'b01:   inc_in = 1'b0;
            2'b10:   inc_in = ~sign_in & (g_in | s_in);
            2'b11:   inc_in = sign_in & (g_in | s_in);
            default: inc_in = 1'b0;
        endcase
    end

    always_comb begin
        cls_in = ClsFinite;
        if (exp_in == {EXP_W{1'b1}}) begin
            cls_in = (frac_in == '0) ? ClsInf : ClsNan;
        end
    end

    logic v1_q, v2_q;
    logic s1_load, s2_load;

    // Stage 2 frees up whenever downstream drains it, so in_ready sees out_ready combinationally.
    assign s2_load  = ~v2_q | out_ready;
    assign s1_load  = ~v1_q | s2_load;
    assign in_ready = s1_load;

    logic                 s1_sign_q;
    logic [EXP_W-1:0]     s1_exp_q;
    logic [OUT_MAN_W-1:0] s1_kept_q;
    logic                 s1_inc_q;
    cls_e                 s1_cls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_kept_q <= '0;
            s1_inc_q  <= 1'b0;
            s1_cls_q  <= ClsFinite;
        end else if (s1_load) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= sign_in;
                s1_exp_q  <= exp_in;
                s1_kept_q <= kept_in;
                s1_inc_q  <= inc_in;
                s1_cls_q  <= cls_in;
            end
        end
    end

    // ---------------- stage 2: add, special-case mux ----------------
    logic [SUM_W-1:0]         sum;
    logic                     sum_ovf;
    logic [EXP_W+OUT_MAN_W:0] res_d;
    logic [EXP_W+OUT_MAN_W:0] res_q;

    // Fraction carry ripples into the exponent, covering subnormal->normal and finite->inf.
    assign sum     = {s1_exp_q, s1_kept_q} + SUM_W'(s1_inc_q);
    assign sum_ovf = (sum[SUM_W-1 -: EXP_W] == {EXP_W{1'b1}});

    always_comb begin
        res_d = {s1_sign_q, sum};
        unique case (s1_cls_q)
            ClsInf:  res_d = {s1_sign_q, {EXP_W{1'b1}}, {OUT_MAN_W{1'b0}}};
            ClsNan:  res_d = {s1_sign_q, {EXP_W{1'b1}}, QNAN_FRAC};
            default: begin
                if (sum_ovf) res_d = {s1_sign_q, {EXP_W{1'b1}}, {OUT_MAN_W{1'b0}}};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            res_q <= '0;
        end else if (s2_load) begin
            v2_q <= v1_q;
            if (v1_q) res_q <= res_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = res_q;

`ifdef BF16_ROUND_FLAGS_EN
    logic       s1_gs_q;
    logic [1:0] flags_d, flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_gs_q <= 1'b0;
        end else if (s1_load && in_valid) begin
            s1_gs_q <= g_in | s_in;
        end
    end

    always_comb begin
        flags_d = 2'b00;
        if (s1_cls_q == ClsFinite) begin
            flags_d = sum_ovf ? 2'b11 : {1'b0, s1_gs_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 2'b00;
        end else if (s2_load && v1_q) begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 2'b00;
`endif

endmodule

// File: tb/tb_bf16_round_pipe.sv
// Self-checking bench for bf16_round_pipe: directed cases, backpressure, reset, random stream.
module tb_bf16_round_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_flags;

    bf16_round_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic saw_stall = 1'b0;
    logic [17:0] exp_cur = '0;
    logic [17:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, want);
    endtask

    // Value-level reference: round the 31-bit magnitude to a multiple of 2^16.
    function automatic logic [17:0] ref_round(input logic [31:0] x, input logic [1:0] m);
        logic        sign;
        int unsigned mag, trunc, rem, r;
        logic        up;
        logic [1:0]  fl;
        logic [15:0] res;
        sign = x[31];
        if (x[30:23] == 8'hFF) begin
            res = (x[22:0] == 0) ? {sign, 15'h7F80} : {sign, 15'h7FC0};
            fl  = 2'b00;
        end else begin
            mag   = {1'b0, x[30:0]};
            trunc = mag / 65536;
            rem   = mag % 65536;
            case (m)
                2'd0:    up = (rem > 32768) || (rem == 32768 && (trunc % 2 == 1));
                2'd1:    up = 1'b0;
                2'd2:    up = !sign && rem != 0;
                default: up = sign && rem != 0;
            endcase
            r = trunc + (up ? 1 : 0);
            if (r >= 32'h7F80) begin
                res = {sign, 15'h7F80};
                fl  = 2'b11;
            end else begin
                res = {sign, r[14:0]};
                fl  = {1'b0, rem != 0};
            end
        end
`ifndef BF16_ROUND_FLAGS_EN
        fl = 2'b00;
`endif
        return {fl, res};
    endfunction

    function automatic logic [17:0] fl_mask(input logic [17:0] v);
`ifdef BF16_ROUND_FLAGS_EN
        return v;
`else
        return {2'b00, v[15:0]};
`endif
    endfunction

    // Scoreboard monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    chk("out_data", {16'b0, out_data}, {16'b0, sb[0][15:0]});
                    chk("out_flags", {30'b0, out_flags}, {30'b0, sb[0][17:16]});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
            if (in_valid && !in_ready) saw_stall = 1'b1;
        end
    end

    // Presents a beat and returns #1 after the edge that accepted it; in_valid is left high.
    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [17:0] want);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        exp_cur  = want;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [17:0] want;
    } vec_t;

    vec_t dir[$];
    int   lat;
    int   n_before;
    logic done_a;

    initial begin
        dir.push_back('{32'h3F808000, 2'd0, {2'b01, 16'h3F80}});
        dir.push_back('{32'h3F818000, 2'd0, {2'b01, 16'h3F82}});
        dir.push_back('{32'h3F800000, 2'd0, {2'b00, 16'h3F80}});
        dir.push_back('{32'hBF808000, 2'd0, {2'b01, 16'hBF80}});
        dir.push_back('{32'hBF808000, 2'd1, {2'b01, 16'hBF80}});
        dir.push_back('{32'hBF808000, 2'd2, {2'b01, 16'hBF80}});
        dir.push_back('{32'hBF808000, 2'd3, {2'b01, 16'hBF81}});
        dir.push_back('{32'h7F7FFFFF, 2'd0, {2'b11, 16'h7F80}});
        dir.push_back('{32'h7F7FFFFF, 2'd1, {2'b01, 16'h7F7F}});
        dir.push_back('{32'hFF7FFFFF, 2'd2, {2'b01, 16'hFF7F}});
        dir.push_back('{32'h7F800000, 2'd0, {2'b00, 16'h7F80}});
        dir.push_back('{32'h7F800001, 2'd0, {2'b00, 16'h7FC0}});
        dir.push_back('{32'hFFC12345, 2'd0, {2'b00, 16'hFFC0}});
        dir.push_back('{32'h007FFFFF, 2'd0, {2'b01, 16'h0080}});
        dir.push_back('{32'h80000000, 2'd3, {2'b00, 16'h8000}});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_out_flags", {30'b0, out_flags}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors, back to back.
        foreach (dir[i]) send(dir[i].d, dir[i].m, fl_mask(dir[i].want));
        idle();
        drain();

        // Latency on an empty pipe.
        send(32'h40490FDB, 2'd0, ref_round(32'h40490FDB, 2'd0));
        idle();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 32'd2);
        drain();

        // Backpressure: 8 beats streamed, out_ready low for cycles 3..6.
        saw_stall = 1'b0;
        n_before  = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(32'h3F800000 + (i << 15), i[1:0], ref_round(32'h3F800000 + (i << 15), i[1:0]));
                end
                idle();
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall_seen", {31'b0, saw_stall}, 32'd1);
        chk("bp_out_count", n_out - n_before, 32'd8);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(32'h41200000, 2'd0, ref_round(32'h41200000, 2'd0));
        send(32'h41300000, 2'd0, ref_round(32'h41300000, 2'd0));
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("postrst_quiet", {31'b0, out_valid}, 32'd0);
        end
        send(32'hC0A00000, 2'd1, ref_round(32'hC0A00000, 2'd1));
        idle();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("postrst_latency", lat, 32'd2);
        drain();

        // Random stream with random gaps and random backpressure.
        done_a = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] d;
                    logic [1:0]  m;
                    d = $urandom;
                    case ($urandom_range(0, 5))
                        0: d[30:23] = 8'hFF;
                        1: d[30:23] = 8'hFE;
                        2: d[30:23] = 8'h00;
                        3: d[15:0]  = 16'h8000;
                        default: ;
                    endcase
                    m = 2'($urandom_range(0, 3));
                    send(d, m, ref_round(d, m));
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                done_a = 1'b1;
            end
            begin
                while (!done_a) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
